xbus_slave_mem: RTL and testbench
=================================

Name: xbus_slave_mem

Overview:
- Byte-addressable memory slave on the xbus. It sits directly downstream of the bus arbiter: it consumes the arbiter's `xbus_start` framing and the granted master's address/data phases.
- Claims transfers whose address falls in its window, inserts programmable wait states, and signals errors.
- Bus-facing outputs are tri-state, so several slaves can share the bus.

Parameters:
- BASE_ADDR, 16'h0000: window base; must be aligned to 2**ADDR_WIDTH.
- ADDR_WIDTH, 8: log2 of window/memory size in bytes (1..15).
- WAIT_STATES, 1: wait cycles inserted before every data beat (0..7).

Ports:
- xbus_clock  in  1  bus clock; all logic on its posedge.
- xbus_reset  in  1  synchronous, active-high reset.
- xbus_start  in  1  arbitration-phase marker from the arbiter.
- xbus_addr  in  16  transfer start address (address phase).
- xbus_size  in  2  beats: 00=1, 01=2, 10=4, 11=8.
- xbus_read  in  1  read request (address phase).
- xbus_write  in  1  write request (address phase).
- xbus_bip  in  1  burst in progress; 0 on the final beat.
- xbus_data  inout  8  write data from master / read data from this slave.
- xbus_wait  out  1  tri-state; 1 = beat stalled.
- xbus_error  out  1  tri-state; 1 = transfer aborted.

Behaviour:
- Reset (sampled high at a posedge):
  - state=IDLE.
  - xbus_wait, xbus_error and xbus_data are 'z.
  - Memory contents are not cleared.
  - Reset mid-transfer aborts it immediately; bytes already written stay written.
- FSM states: IDLE, ADDR, DATA, ERR.
- IDLE: xbus_start==1 at a posedge -> ADDR.
- ADDR (one cycle, the address phase). At its closing posedge:
  - Claim if (read^write)==1 and addr[15:ADDR_WIDTH]==BASE_ADDR[15:ADDR_WIDTH].
  - On claim, latch ptr=addr[ADDR_WIDTH-1:0], dir=write, beats_left=1<<size, wcnt=WAIT_STATES, then -> DATA.
  - read&&write both 1 inside the window -> ERR.
  - Otherwise -> IDLE: no-op or other slave; outputs stay 'z.
- DATA:
  - Slave drives xbus_wait = (wcnt!=0) and xbus_error=0.
  - wcnt decrements each stalled cycle.
  - Transfer cycle (wait==0):
    - Write: mem[ptr] <= xbus_data at the closing posedge.
    - Read: xbus_data driven with mem[ptr] (asynchronous array read) for the whole cycle.
  - After each transfer: ptr+1, beats_left-1, wcnt reloaded to WAIT_STATES.
  - xbus_bip==0 in the transfer cycle -> IDLE.
  - Early bip==0 (beats_left>1) is a legal short burst.
  - If ptr+1 would exceed 2**ADDR_WIDTH-1 while bip==1, or beats_left==1 with bip==1 -> ERR next cycle.
- ERR (one cycle):
  - xbus_error=1, xbus_wait=0, xbus_data='z; no memory update.
  - -> IDLE.
- Output enables:
  - xbus_wait/xbus_error are driven only in DATA and ERR; 'z otherwise.
  - xbus_data is driven only on read transfer cycles.
  - Never drive xbus_data during write or wait cycles.
- xbus_start in any state other than IDLE is ignored.
- With WAIT_STATES=0, the first beat transfers in the cycle immediately after the address phase.
- Throughput: 1 byte per (WAIT_STATES+1) cycles.

Decomposition:
- xbus_pkg holds:
  - the size-encoding constants (SIZE_1B..SIZE_8B) and the beats_from_size function;
  - the xbus_slave_state_e enum {IDLE, ADDR, DATA, ERR}.
- Sub-module xbus_slave_mem_array: 2**ADDR_WIDTH x 8 register array, one synchronous write port, one asynchronous read port, no reset.

Test Plan:
- Write then read, defaults: write size=10 at addr 16'h0010 with data 11,22,33,44, bip 1,1,1,0 -> 4 beats, each with wait=1 then 0. Read of the same region returns 11,22,33,44 on the wait==0 cycles; xbus_error stays 0.
- Out-of-window: address phase at 16'h0100 with read=1 -> xbus_wait, xbus_error and xbus_data stay 'z for the whole transfer.
- Window-end overrun: write size=01 at 16'h00FF with bip=1 on beat 1 -> byte at 00FF written, then one cycle xbus_error=1 -> IDLE. No wrap: 16'h0000 unchanged.
- Excess bip: read size=00 at 16'h0005 with bip held 1 -> one data beat, then ERR cycle with error=1.
- No-op and illegal direction: read=write=0 -> slave idle, outputs 'z. read=write=1 at 16'h0020 -> single error pulse.
- Reset mid-burst: assert xbus_reset during beat 2 of an 8-beat write -> next cycle all outputs 'z, state IDLE. Beat-1 byte retained; a subsequent transfer completes normally.

Source files
------------

// File: rtl/xbus_pkg.sv
// xbus_pkg: shared xbus size encodings and slave FSM state type
package xbus_pkg;
   localparam logic [1:0] SIZE_1B = 2'b00;
   localparam logic [1:0] SIZE_2B = 2'b01;
   localparam logic [1:0] SIZE_4B = 2'b10;
   localparam logic [1:0] SIZE_8B = 2'b11;

   typedef enum logic [1:0] {IDLE, ADDR, DATA, ERR} xbus_slave_state_e;

   function automatic logic [3:0] beats_from_size(input logic [1:0] size);
      return 4'd1 << size;
   endfunction
endpackage

// File: rtl/xbus_slave_mem_array.sv
// xbus_slave_mem_array: byte register array, synchronous write, asynchronous read, no reset
module xbus_slave_mem_array #(
   parameter int ADDR_WIDTH = 8
) (
   input  logic                  xbus_clock,
   input  logic                  we,
   input  logic [ADDR_WIDTH-1:0] waddr,
   input  logic [7:0]            wdata,
   input  logic [ADDR_WIDTH-1:0] raddr,
   output logic [7:0]            rdata
);
   logic [7:0] mem [2**ADDR_WIDTH];

   always_ff @(posedge xbus_clock)
      if (we) mem[waddr] <= wdata;

   assign rdata = mem[raddr];
endmodule

// File: rtl/xbus_slave_mem.sv
// xbus_slave_mem: windowed byte memory slave with wait states and error reporting on the shared xbus
module xbus_slave_mem
   import xbus_pkg::*;
#(
   parameter logic [15:0] BASE_ADDR   = 16'h0000,
   parameter int          ADDR_WIDTH  = 8,
   parameter int          WAIT_STATES = 1
) (
   input  logic        xbus_clock,
   input  logic        xbus_reset,
   input  logic        xbus_start,
   input  logic [15:0] xbus_addr,
   input  logic [1:0]  xbus_size,
   input  logic        xbus_read,
   input  logic        xbus_write,
   input  logic        xbus_bip,
   inout  wire  [7:0]  xbus_data,
   output logic        xbus_wait,
   output logic        xbus_error
);
   xbus_slave_state_e     state;
   logic [ADDR_WIDTH-1:0] ptr;
   logic                  dir;
   logic [3:0]            beats_left;
   logic [2:0]            wcnt;
   logic [7:0]            rdata;
   logic                  in_win;
   logic                  xfer;

   assign in_win = (xbus_addr >> ADDR_WIDTH) == (BASE_ADDR >> ADDR_WIDTH);
   assign xfer   = state == DATA && wcnt == 3'd0;

   // a reset landing on a transfer cycle must not commit that beat
   xbus_slave_mem_array #(.ADDR_WIDTH(ADDR_WIDTH)) u_array (
      .xbus_clock (xbus_clock),
      .we         (xfer && dir && !xbus_reset),
      .waddr      (ptr),
      .wdata      (xbus_data),
      .raddr      (ptr),
      .rdata      (rdata)
   );

   assign xbus_wait  = state == DATA ? wcnt != 3'd0 : state == ERR ? 1'b0 : 1'bz;
   assign xbus_error = state == DATA ? 1'b0 : state == ERR ? 1'b1 : 1'bz;
   assign xbus_data  = xfer && !dir ? rdata : 8'bz;

   always_ff @(posedge xbus_clock)
      if (xbus_reset) state <= IDLE;
      else
         case (state)
            IDLE: if (xbus_start) state <= ADDR;
            ADDR: begin
               ptr        <= xbus_addr[ADDR_WIDTH-1:0];
               dir        <= xbus_write;
               beats_left <= beats_from_size(xbus_size);
               wcnt       <= 3'(WAIT_STATES);
               state      <= !in_win ? IDLE : (xbus_read ^ xbus_write) ? DATA :
                             (xbus_read && xbus_write) ? ERR : IDLE;
            end
            DATA:
               if (wcnt != 3'd0) wcnt <= wcnt - 3'd1;
               else begin
                  ptr        <= ptr + ADDR_WIDTH'(1);
                  beats_left <= beats_left - 4'd1;
                  wcnt       <= 3'(WAIT_STATES);
                  // bip still high on the last beat or at the window end means an overrun
                  state      <= !xbus_bip ? IDLE : (beats_left == 4'd1 || &ptr) ? ERR : DATA;
               end
            ERR: state <= IDLE;
            default: state <= IDLE;
         endcase
endmodule

// File: tb/tb_xbus_slave_mem.sv
// tb_xbus_slave_mem: cycle-vector table plus hand-written read-back sequences
module tb_xbus_slave_mem;
   localparam logic [1:0] CZ = 2'd2, DC = 2'd3;
   localparam logic [1:0] DV = 2'd0, DZ = 2'd1, DD = 2'd2;

   typedef struct {
      logic        rst, st;
      logic [15:0] a;
      logic [1:0]  sz;
      logic        r, w, b, de;
      logic [7:0]  d;
      logic [1:0]  ew, ee, dm;
      logic [7:0]  dv;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst, st, r, w, b, de;
   logic [15:0] a;
   logic [1:0]  sz;
   logic [7:0]  d;
   wire  [7:0]  xbus_data;
   wire         xbus_wait, xbus_error;
   int          n_cmp = 0, n_bad = 0;
   vec_t        tv[$];

   assign xbus_data = de ? d : 8'bz;

   always #5 clk = ~clk;

   xbus_slave_mem dut (
      .xbus_clock (clk),
      .xbus_reset (rst),
      .xbus_start (st),
      .xbus_addr  (a),
      .xbus_size  (sz),
      .xbus_read  (r),
      .xbus_write (w),
      .xbus_bip   (b),
      .xbus_data  (xbus_data),
      .xbus_wait  (xbus_wait),
      .xbus_error (xbus_error)
   );

   function automatic vec_t mk(logic rs, logic s, logic [15:0] aa, logic [1:0] z, logic rr, logic ww,
                               logic bb, logic dd, logic [7:0] dat, logic [1:0] ew, logic [1:0] ee,
                               logic [1:0] dm, logic [7:0] dv);
      vec_t v;
      v.rst = rs; v.st = s; v.a = aa; v.sz = z; v.r = rr; v.w = ww; v.b = bb; v.de = dd; v.d = dat;
      v.ew = ew; v.ee = ee; v.dm = dm; v.dv = dv;
      return v;
   endfunction

   function automatic vec_t idle(logic s);
      return mk(0, s, 0, 0, 0, 0, 0, 0, 0, CZ, CZ, DZ, 0);
   endfunction
   function automatic vec_t ap(logic [15:0] aa, logic [1:0] z, logic rr, logic ww);
      return mk(0, 0, aa, z, rr, ww, 0, 0, 0, CZ, CZ, DZ, 0);
   endfunction
   function automatic vec_t wt(logic s);
      return mk(0, s, 0, 0, 0, 0, 1, 0, 0, 2'd1, 2'd0, DZ, 0);
   endfunction
   function automatic vec_t wx(logic [7:0] dat, logic bb, logic rs);
      return mk(rs, 0, 0, 0, 0, 0, bb, 1, dat, 2'd0, 2'd0, DV, dat);
   endfunction
   function automatic vec_t rx(logic [7:0] dv, logic bb, logic [1:0] dm);
      return mk(0, 0, 0, 0, 0, 0, bb, 0, 0, 2'd0, 2'd0, dm, dv);
   endfunction
   function automatic vec_t er();
      return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'd0, 2'd1, DZ, 0);
   endfunction

   task automatic chk1(input string nm, input int row, input logic isz, input logic v, input logic [1:0] c);
      if (c == DC) return;
      n_cmp++;
      if (c == CZ ? !isz : (isz || v != c[0])) begin
         n_bad++;
         $display("FAIL %s row %0d: got %s, need %s", nm, row, isz ? "z" : $sformatf("%b", v),
                  c == CZ ? "z" : $sformatf("%b", c[0]));
      end
   endtask

   task automatic chk8(input string nm, input int row, input logic isz, input logic [7:0] v,
                       input logic [1:0] c, input logic [7:0] e);
      if (c == DD) return;
      n_cmp++;
      if (c == DZ ? !isz : (isz || v != e)) begin
         n_bad++;
         $display("FAIL %s row %0d: got %s, need %s", nm, row, isz ? "z" : $sformatf("%h", v),
                  c == DZ ? "z" : $sformatf("%h", e));
      end
   endtask

   task automatic apply(input vec_t v);
      rst = v.rst; st = v.st; a = v.a; sz = v.sz; r = v.r; w = v.w; b = v.b; de = v.de; d = v.d;
   endtask

   task automatic rd(input logic [15:0] aa, input logic [7:0] e);
      int n;
      apply(idle(1));
      @(posedge clk); #1;
      apply(ap(aa, 2'b00, 1, 0));
      @(posedge clk); #1;
      r = 1'b0;
      n = 0;
      @(negedge clk);
      while (xbus_wait !== 1'b0 && n < 10) begin
         @(posedge clk); #1;
         @(negedge clk);
         n++;
      end
      if (n >= 10) begin
         n_cmp++; n_bad++;
         $display("FAIL readback %h: no transfer cycle within 10 cycles", aa);
      end else chk8($sformatf("readback_%h", aa), -1, xbus_data === 8'bz, xbus_data, DV, e);
      @(posedge clk); #1;
   endtask

   initial begin
      apply(idle(0));
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      // 4-beat write then read at 0x0010; start asserted mid-burst must be ignored
      tv.push_back(idle(1)); tv.push_back(ap(16'h0010, 2'b10, 0, 1));
      tv.push_back(wt(0)); tv.push_back(wx(8'h11, 1, 0)); tv.push_back(wt(1)); tv.push_back(wx(8'h22, 1, 0));
      tv.push_back(wt(0)); tv.push_back(wx(8'h33, 1, 0)); tv.push_back(wt(0)); tv.push_back(wx(8'h44, 0, 0));
      tv.push_back(idle(1)); tv.push_back(ap(16'h0010, 2'b10, 1, 0));
      tv.push_back(wt(0)); tv.push_back(rx(8'h11, 1, DV)); tv.push_back(wt(0)); tv.push_back(rx(8'h22, 1, DV));
      tv.push_back(wt(0)); tv.push_back(rx(8'h33, 1, DV)); tv.push_back(wt(0)); tv.push_back(rx(8'h44, 0, DV));
      // out-of-window read stays silent
      tv.push_back(idle(1)); tv.push_back(ap(16'h0100, 2'b00, 1, 0));
      tv.push_back(idle(0)); tv.push_back(idle(0)); tv.push_back(idle(0));
      // seed 0x0000, then overrun at window end
      tv.push_back(idle(1)); tv.push_back(ap(16'h0000, 2'b00, 0, 1)); tv.push_back(wt(0)); tv.push_back(wx(8'h5A, 0, 0));
      tv.push_back(idle(1)); tv.push_back(ap(16'h00FF, 2'b01, 0, 1)); tv.push_back(wt(0)); tv.push_back(wx(8'hAB, 1, 0));
      tv.push_back(er()); tv.push_back(idle(0));
      // excess bip on single-beat read
      tv.push_back(idle(1)); tv.push_back(ap(16'h0005, 2'b00, 1, 0)); tv.push_back(wt(0)); tv.push_back(rx(0, 1, DD));
      tv.push_back(er()); tv.push_back(idle(0));
      // no-op direction, then both directions
      tv.push_back(idle(1)); tv.push_back(ap(16'h0020, 2'b00, 0, 0)); tv.push_back(idle(0)); tv.push_back(idle(0));
      tv.push_back(idle(1)); tv.push_back(ap(16'h0020, 2'b00, 1, 1)); tv.push_back(er()); tv.push_back(idle(0));
      // reset on beat 2 of an 8-beat write
      tv.push_back(idle(1)); tv.push_back(ap(16'h0030, 2'b11, 0, 1)); tv.push_back(wt(0)); tv.push_back(wx(8'hC1, 1, 0));
      tv.push_back(wt(0)); tv.push_back(wx(8'hC2, 1, 1)); tv.push_back(idle(0)); tv.push_back(idle(0));
      for (int i = 0; i < tv.size(); i++) begin
         apply(tv[i]);
         @(negedge clk);
         chk1("wait", i, xbus_wait === 1'bz, xbus_wait, tv[i].ew);
         chk1("error", i, xbus_error === 1'bz, xbus_error, tv[i].ee);
         chk8("data", i, xbus_data === 8'bz, xbus_data, tv[i].dm, tv[i].dv);
         @(posedge clk); #1;
      end
      rd(16'h00FF, 8'hAB);
      rd(16'h0000, 8'h5A);
      rd(16'h0030, 8'hC1);
      rd(16'h0013, 8'h44);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
